mips_pipeline_cpu: RTL and testbench

32-bit MIPS-subset processor with a classic 5-stage pipeline (IF, ID, EX, MEM, WB), hazard forwarding and load-use stalling. It is the top-level compute block. It drives a single combinational, unclocked memory that has separate instruction and data ports. The internal register file is instantiated as `regFile` and holds the array `regFile[0:31]`, so benches can probe register contents hierarchically.

---
 rtl/mips_pipeline_cpu.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_mips_pipeline_cpu.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mips_pipeline_cpu.sv
// rtl/mips_pipeline_cpu.sv - 5-stage MIPS-subset pipeline with forwarding and load-use stall
//
// Purpose: IF/ID/EX/MEM/WB pipeline executing add/sub/and/or/slt/addi/lw/sw/beq/j.
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous active-low reset
//   instructionAddress  fetch PC (byte address)
//   instruction         instruction word for instructionAddress (combinational)
//   dataAddress         load/store address from EX/MEM
//   dataIn              store data from EX/MEM
//   MemRead / MemWrite  lw / sw currently in MEM
//   dataOut             load data for dataAddress (combinational)

module mips_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] regFile [0:31];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regFile[i] <= '0;
        end else if (we && (wa != 5'd0)) begin
            regFile[wa] <= wd;
        end
    end

    // Same-cycle write data is bypassed so ID sees the WB result without an extra stage.
    always_comb begin
        rd1 = regFile[ra1];
        rd2 = regFile[ra2];
        if (we && (wa == ra1)) rd1 = wd;
        if (we && (wa == ra2)) rd2 = wd;
        if (ra1 == 5'd0) rd1 = '0;
        if (ra2 == 5'd0) rd2 = '0;
    end
endmodule

module mips_pipeline_cpu (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instructionAddress,
    input  logic [31:0] instruction,
    output logic [31:0] dataAddress,
    output logic [31:0] dataIn,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] dataOut
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ifid_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic        is_beq;
        alu_op_e     alu_op;
        logic [4:0]  dest;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc4;
    } idex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] store;
    } exmem_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] load;
    } memwb_t;

    logic [31:0] pc_q, pc_d;
    ifid_t       ifid_q, ifid_d;
    idex_t       idex_q, idex_d;
    exmem_t      exmem_q, exmem_d;
    memwb_t      memwb_q, memwb_d;

    // ---------------- ID ----------------
    logic [5:0]  id_op, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_imm, id_rs_val, id_rt_val, id_jump_target;
    logic        id_is_jump;
    idex_t       id_dec;

    // ---------------- EX / WB ----------------
    logic [31:0] wb_data;
    logic [31:0] ex_a, ex_b, ex_alu_b, ex_alu;
    logic [31:0] ex_branch_target;
    logic        ex_branch_taken;
    logic        load_use;
    logic [31:0] pc_plus4;

    assign id_op    = ifid_q.instr[31:26];
    assign id_rs    = ifid_q.instr[25:21];
    assign id_rt    = ifid_q.instr[20:16];
    assign id_rd    = ifid_q.instr[15:11];
    assign id_funct = ifid_q.instr[5:0];
    assign id_imm   = {{16{ifid_q.instr[15]}}, ifid_q.instr[15:0]};
    assign id_jump_target = {ifid_q.pc4[31:28], ifid_q.instr[25:0], 2'b00};

    assign wb_data = memwb_q.mem_to_reg ? memwb_q.load : memwb_q.alu;

    mips_regfile regFile (
        .clk   (clk),
        .reset (reset),
        .ra1   (id_rs),
        .ra2   (id_rt),
        .rd1   (id_rs_val),
        .rd2   (id_rt_val),
        .we    (memwb_q.reg_write),
        .wa    (memwb_q.dest),
        .wd    (wb_data)
    );

    // Decode: anything not recognised leaves every write enable at 0 (NOP).
    always_comb begin
        id_dec        = '0;
        id_dec.alu_op = ALU_ADD;
        id_dec.rs     = id_rs;
        id_dec.rt     = id_rt;
        id_dec.a      = id_rs_val;
        id_dec.b      = id_rt_val;
        id_dec.imm    = id_imm;
        id_dec.pc4    = ifid_q.pc4;
        id_is_jump    = 1'b0;
        case (id_op)
            OP_RTYPE: begin
                case (id_funct)
                    FN_ADD: begin id_dec.reg_write = 1'b1; id_dec.dest = id_rd; id_dec.alu_op = ALU_ADD; end
                    FN_SUB: begin id_dec.reg_write = 1'b1; id_dec.dest = id_rd; id_dec.alu_op = ALU_SUB; end
                    FN_AND: begin id_dec.reg_write = 1'b1; id_dec.dest = id_rd; id_dec.alu_op = ALU_AND; end
                    FN_OR:  begin id_dec.reg_write = 1'b1; id_dec.dest = id_rd; id_dec.alu_op = ALU_OR;  end
                    FN_SLT: begin id_dec.reg_write = 1'b1; id_dec.dest = id_rd; id_dec.alu_op = ALU_SLT; end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                id_dec.reg_write = 1'b1;
                id_dec.alu_src   = 1'b1;
                id_dec.dest      = id_rt;
            end
            OP_LW: begin
                id_dec.reg_write  = 1'b1;
                id_dec.mem_read   = 1'b1;
                id_dec.mem_to_reg = 1'b1;
                id_dec.alu_src    = 1'b1;
                id_dec.dest       = id_rt;
            end
            OP_SW: begin
                id_dec.mem_write = 1'b1;
                id_dec.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                id_dec.is_beq = 1'b1;
                id_dec.alu_op = ALU_SUB;
            end
            OP_J: id_is_jump = 1'b1;
            default: ;
        endcase
    end

    // A lw in EX cannot forward in time for the instruction now in ID.
    assign load_use = idex_q.mem_read && (idex_q.dest != 5'd0) &&
                      ((idex_q.dest == id_rs) || (idex_q.dest == id_rt));

    // Forwarding: the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        ex_a = idex_q.a;
        if (exmem_q.reg_write && (exmem_q.dest != 5'd0) && (exmem_q.dest == idex_q.rs))
            ex_a = exmem_q.alu;
        else if (memwb_q.reg_write && (memwb_q.dest != 5'd0) && (memwb_q.dest == idex_q.rs))
            ex_a = wb_data;

        ex_b = idex_q.b;
        if (exmem_q.reg_write && (exmem_q.dest != 5'd0) && (exmem_q.dest == idex_q.rt))
            ex_b = exmem_q.alu;
        else if (memwb_q.reg_write && (memwb_q.dest != 5'd0) && (memwb_q.dest == idex_q.rt))
            ex_b = wb_data;
    end

    assign ex_alu_b = idex_q.alu_src ? idex_q.imm : ex_b;

    always_comb begin
        ex_alu = '0;
        case (idex_q.alu_op)
            ALU_ADD: ex_alu = ex_a + ex_alu_b;
            ALU_SUB: ex_alu = ex_a - ex_alu_b;
            ALU_AND: ex_alu = ex_a & ex_alu_b;
            ALU_OR:  ex_alu = ex_a | ex_alu_b;
            ALU_SLT: ex_alu = {31'd0, ($signed(ex_a) < $signed(ex_alu_b))};
            default: ex_alu = '0;
        endcase
    end

    assign ex_branch_taken  = idex_q.is_beq && (ex_a == ex_b);
    assign ex_branch_target = idex_q.pc4 + {idex_q.imm[29:0], 2'b00};
    assign pc_plus4         = pc_q + 32'd4;

    // Next-state for every pipeline register. Priority: taken beq, then stall, then j.
    always_comb begin
        pc_d        = pc_plus4;
        ifid_d.instr = instruction;
        ifid_d.pc4   = pc_plus4;
        idex_d      = id_dec;

        exmem_d.reg_write  = idex_q.reg_write;
        exmem_d.mem_read   = idex_q.mem_read;
        exmem_d.mem_write  = idex_q.mem_write;
        exmem_d.mem_to_reg = idex_q.mem_to_reg;
        exmem_d.dest       = idex_q.dest;
        exmem_d.alu        = ex_alu;
        exmem_d.store      = ex_b;

        memwb_d.reg_write  = exmem_q.reg_write;
        memwb_d.mem_to_reg = exmem_q.mem_to_reg;
        memwb_d.dest       = exmem_q.dest;
        memwb_d.alu        = exmem_q.alu;
        memwb_d.load       = dataOut;

        if (ex_branch_taken) begin
            pc_d   = ex_branch_target;
            ifid_d = '0;
            idex_d = '0;
        end else if (load_use) begin
            pc_d   = pc_q;
            ifid_d = ifid_q;
            idex_d = '0;
        end else if (id_is_jump) begin
            pc_d   = id_jump_target;
            ifid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            ifid_q  <= '0;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign instructionAddress = pc_q;
    assign dataAddress        = exmem_q.alu;
    assign dataIn             = exmem_q.store;
    assign MemRead            = exmem_q.mem_read;
    assign MemWrite           = exmem_q.mem_write;
endmodule

// File: tb/tb_mips_pipeline_cpu.sv
// tb/tb_mips_pipeline_cpu.sv - directed bench for mips_pipeline_cpu
module tb_mips_pipeline_cpu;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instructionAddress, instruction;
    logic [31:0] dataAddress, dataIn, dataOut;
    logic        MemRead, MemWrite;

    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:63];

    int errors = 0;
    int checks = 0;

    mips_pipeline_cpu dut (
        .clk                (clk),
        .reset              (reset),
        .instructionAddress (instructionAddress),
        .instruction        (instruction),
        .dataAddress        (dataAddress),
        .dataIn             (dataIn),
        .MemRead            (MemRead),
        .MemWrite           (MemWrite),
        .dataOut            (dataOut)
    );

    always #5 clk = ~clk;

    assign instruction = imem[instructionAddress[9:2]];
    assign dataOut     = dmem[dataAddress[7:2]];
    always @(posedge clk) if (MemWrite) dmem[dataAddress[7:2]] <= dataIn;

    typedef struct {
        logic [31:0] pc;
        logic        mr;
        logic        mw;
        logic [31:0] addr;
        logic [31:0] din;
    } cyc_vec_t;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] val;
    } reg_vec_t;

    cyc_vec_t cyc_tab [30];
    reg_vec_t reg_tab [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(logic [25:0] t);
        return {6'h02, t};
    endfunction

    task automatic check_zero_regs(input string name);
        int nz = 0;
        for (int i = 0; i < 32; i++) if (dut.regFile.regFile[i] !== 32'd0) nz++;
        chk(name, nz, 0);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 22; i++)
            chk($sformatf("%s reg$%0d", tag, reg_tab[i].r), dut.regFile.regFile[reg_tab[i].r], reg_tab[i].val);
        chk({tag, " dmem[8]"}, dmem[2], 32'd12);
        chk({tag, " dmem[12]"}, dmem[3], 32'hFFFF_FFFF);
    endtask

    // Starts right at the negedge where reset was released (cycle 0).
    task automatic run_program(input string tag);
        for (int n = 0; n < 30; n++) begin
            chk($sformatf("%s c%0d pc", tag, n), instructionAddress, cyc_tab[n].pc);
            chk($sformatf("%s c%0d MemRead", tag, n), {31'd0, MemRead}, {31'd0, cyc_tab[n].mr});
            chk($sformatf("%s c%0d MemWrite", tag, n), {31'd0, MemWrite}, {31'd0, cyc_tab[n].mw});
            if (cyc_tab[n].mr || cyc_tab[n].mw)
                chk($sformatf("%s c%0d dataAddress", tag, n), dataAddress, cyc_tab[n].addr);
            if (cyc_tab[n].mw)
                chk($sformatf("%s c%0d dataIn", tag, n), dataIn, cyc_tab[n].din);
            if (n == 4) chk({tag, " $1 before 5th edge"}, dut.regFile.regFile[1], 32'd0);
            if (n == 5) chk({tag, " $1 after 5th edge"}, dut.regFile.regFile[1], 32'd5);
            @(negedge clk);
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        logic [31:0] pcs [30];

        for (int i = 0; i < 256; i++) imem[i] = 32'd0;
        for (int i = 0; i < 64; i++) dmem[i] = 32'd0;

        // Expected fetch address per cycle: stalls at c8/c9 and c26/c27, j redirect at c17.
        pcs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h20,
                32'h24, 32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h40, 32'h44, 32'h48,
                32'h4C, 32'h50, 32'h54, 32'h58, 32'h5C, 32'h60, 32'h64, 32'h64, 32'h68, 32'h6C};
        for (int n = 0; n < 30; n++) cyc_tab[n] = '{pcs[n], 1'b0, 1'b0, 32'd0, 32'd0};
        cyc_tab[8]  = '{32'h20, 1'b0, 1'b1, 32'd8,  32'd12};
        cyc_tab[9]  = '{32'h20, 1'b1, 1'b0, 32'd8,  32'd0};
        cyc_tab[26] = '{32'h64, 1'b0, 1'b1, 32'd12, 32'hFFFF_FFFF};
        cyc_tab[27] = '{32'h64, 1'b1, 1'b0, 32'd12, 32'd0};

        reg_tab = '{'{5'd0, 32'd0}, '{5'd1, 32'd5}, '{5'd2, 32'd7}, '{5'd3, 32'd12},
                    '{5'd4, 32'hFFFF_FFFE}, '{5'd5, 32'd1}, '{5'd6, 32'd12}, '{5'd7, 32'd24},
                    '{5'd8, 32'd0}, '{5'd9, 32'd0}, '{5'd10, 32'd0}, '{5'd11, 32'd3},
                    '{5'd12, 32'd4}, '{5'd13, 32'd6}, '{5'd14, 32'd7}, '{5'd15, 32'd1},
                    '{5'd16, 32'd0}, '{5'd17, 32'hFFFF_FFFF}, '{5'd18, 32'd4},
                    '{5'd19, 32'hFFFF_FFFF}, '{5'd20, 32'd0}, '{5'd21, 32'd0}};

        // Reset state with NOP memory.
        repeat (2) @(negedge clk);
        chk("reset pc", instructionAddress, 32'd0);
        chk("reset dataAddress", dataAddress, 32'd0);
        chk("reset dataIn", dataIn, 32'd0);
        chk("reset MemRead", {31'd0, MemRead}, 32'd0);
        chk("reset MemWrite", {31'd0, MemWrite}, 32'd0);
        check_zero_regs("reset regs");

        reset = 1'b1;
        for (int n = 0; n < 8; n++) begin
            chk($sformatf("nop c%0d pc", n), instructionAddress, 32'(4 * n));
            chk($sformatf("nop c%0d mem ctrl", n), {30'd0, MemRead, MemWrite}, 32'd0);
            @(negedge clk);
        end
        check_zero_regs("nop regs");

        // Program.
        imem[0]  = enc_i(6'h08, 0, 1, 16'd5);
        imem[1]  = enc_i(6'h08, 0, 2, 16'd7);
        imem[2]  = enc_r(1, 2, 3, 6'h20);
        imem[3]  = enc_r(1, 2, 4, 6'h22);
        imem[4]  = enc_r(1, 2, 5, 6'h2A);
        imem[5]  = enc_i(6'h2B, 0, 3, 16'd8);
        imem[6]  = enc_i(6'h23, 0, 6, 16'd8);
        imem[7]  = enc_r(6, 6, 7, 6'h20);
        imem[8]  = enc_i(6'h04, 1, 1, 16'd2);
        imem[9]  = enc_i(6'h08, 0, 8, 16'd1);
        imem[10] = enc_i(6'h08, 0, 9, 16'd1);
        imem[11] = enc_i(6'h08, 0, 11, 16'd3);
        imem[12] = enc_i(6'h04, 1, 2, 16'd2);
        imem[13] = enc_i(6'h08, 0, 12, 16'd4);
        imem[14] = enc_j(26'h10);
        imem[15] = enc_i(6'h08, 0, 10, 16'd1);
        imem[16] = enc_i(6'h08, 0, 0, 16'd9);
        imem[17] = enc_r(4, 2, 13, 6'h24);
        imem[18] = enc_r(1, 2, 14, 6'h25);
        imem[19] = enc_r(4, 1, 15, 6'h2A);
        imem[20] = enc_r(1, 4, 16, 6'h2A);
        imem[21] = enc_i(6'h08, 0, 17, 16'hFFFF);
        imem[22] = enc_i(6'h2B, 0, 17, 16'd12);
        imem[23] = enc_i(6'h23, 0, 19, 16'd12);
        imem[24] = enc_r(19, 1, 18, 6'h20);
        imem[25] = enc_i(6'h3F, 0, 20, 16'h0055);
        imem[26] = enc_r(1, 2, 21, 6'h21);

        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_program("run1");
        check_regs("run1");

        // Mid-program asynchronous reset, away from any clock edge.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midreset pc", instructionAddress, 32'd0);
        chk("midreset mem ctrl", {30'd0, MemRead, MemWrite}, 32'd0);
        chk("midreset dataAddress", dataAddress, 32'd0);
        chk("midreset dataIn", dataIn, 32'd0);
        check_zero_regs("midreset regs");
        @(negedge clk);
        reset = 1'b1;
        run_program("run2");
        check_regs("run2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
